// File: rtl/si_pkg.sv
// si_pkg: shared constants and types for the SI transmit path.
// Buffer geometry, stop-bit shape, TX FSM states and a length clamp.
package si_pkg;

    localparam int SI_TX_WORDS     = 3;
    localparam int SI_TX_MAX_BYTES = 12;
    localparam int SI_STOP_LOW_Q   = 2;
    localparam int SI_STOP_GUARD_Q = 2;

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_GUARD
    } si_tx_state_e;

    function automatic logic [3:0] si_clamp_len(input logic [6:0] len);
        if (len > 7'(SI_TX_MAX_BYTES))
            return 4'(SI_TX_MAX_BYTES);
        return len[3:0];
    endfunction

endpackage

// File: rtl/si_quantum_timer.sv
// si_quantum_timer: divides clk into Joybus quanta.
// Emits a 1-cycle tick in the last cycle of every quantum while running.
module si_quantum_timer #(
    parameter int QUANTUM_CYCLES = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int CW = (QUANTUM_CYCLES > 2) ? $clog2(QUANTUM_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(QUANTUM_CYCLES - 1));

    // Cycle counter within the current quantum, aligned to frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (restart || !run || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/si_tx_phy.sv
// si_tx_phy: Joybus bit-level transmitter driving the open-drain SI line.
// Optional SI_TX_LINE_CHECK_EN: abort with tx_error when released line reads low.
import si_pkg::*;

module si_tx_phy #(
    parameter int QUANTUM_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_reset,
    input  logic        tx_start,
    input  logic [6:0]  tx_length,
    input  logic [31:0] tx_data,
    input  logic [2:0]  tx_wmask,
    input  logic        si_dq_i,
    output logic        si_dq_oe,
    output logic        tx_busy,
    output logic        tx_error
);

    si_tx_state_e                    state;
    logic [SI_TX_WORDS-1:0][31:0]    tx_buf;
    logic [3:0]                      len_q;
    logic [1:0]                      phase;
    logic [6:0]                      bit_idx;
    logic                            err_q;
    logic                            q_tick;
    logic                            start_ok;
    logic                            line_fault;
    logic                            restart;
    logic                            cur_bit;
    logic [6:0]                      next_idx;
    logic [6:0]                      end_idx;

    assign cur_bit  = tx_buf[bit_idx[6:5]][~bit_idx[4:0]];
    assign next_idx = bit_idx + 7'd1;
    assign end_idx  = {len_q, 3'b000};
    assign start_ok = (state == IDLE) && tx_start && !tx_reset;

`ifdef SI_TX_LINE_CHECK_EN
    assign line_fault = q_tick && tx_busy && !si_dq_oe && !si_dq_i;
`else
    logic unused_si_dq;
    assign unused_si_dq = si_dq_i;
    assign line_fault   = 1'b0;
`endif

    assign restart  = start_ok || tx_reset || line_fault;
    assign tx_error = err_q;

    si_quantum_timer #(
        .QUANTUM_CYCLES(QUANTUM_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .run     (tx_busy),
        .tick    (q_tick)
    );

    // Buffer loads, frame sequencing and registered line/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx_buf   <= '0;
            len_q    <= '0;
            phase    <= '0;
            bit_idx  <= '0;
            err_q    <= 1'b0;
            si_dq_oe <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            for (int k = 0; k < SI_TX_WORDS; k++)
                if (tx_wmask[k] && !tx_busy)
                    tx_buf[k] <= tx_data;

            if (tx_reset || line_fault) begin
                state    <= IDLE;
                si_dq_oe <= 1'b0;
                tx_busy  <= 1'b0;
                err_q    <= line_fault && !tx_reset;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tx_start) begin
                            len_q    <= si_clamp_len(tx_length);
                            bit_idx  <= '0;
                            phase    <= '0;
                            si_dq_oe <= 1'b1;
                            tx_busy  <= 1'b1;
                            err_q    <= 1'b0;
                            state    <= (si_clamp_len(tx_length) == 4'd0) ?
                                        STOP_LOW : BIT_LOW;
                        end
                    end
                    BIT_LOW: begin
                        if (q_tick) begin
                            phase <= phase + 2'd1;
                            if (phase == (cur_bit ? 2'd0 : 2'd2)) begin
                                state    <= BIT_HIGH;
                                si_dq_oe <= 1'b0;
                            end
                        end
                    end
                    BIT_HIGH: begin
                        if (q_tick) begin
                            phase <= phase + 2'd1;
                            if (phase == 2'd3) begin
                                bit_idx  <= next_idx;
                                si_dq_oe <= 1'b1;
                                state    <= (next_idx == end_idx) ?
                                            STOP_LOW : BIT_LOW;
                            end
                        end
                    end
                    STOP_LOW: begin
                        if (q_tick) begin
                            phase <= phase + 2'd1;
                            if (phase == 2'(SI_STOP_LOW_Q - 1)) begin
                                state    <= STOP_GUARD;
                                si_dq_oe <= 1'b0;
                            end
                        end
                    end
                    STOP_GUARD: begin
                        if (q_tick) begin
                            phase <= phase + 2'd1;
                            if (phase ==
                                2'(SI_STOP_LOW_Q + SI_STOP_GUARD_Q - 1)) begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        si_dq_oe <= 1'b0;
                        tx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_si_tx_phy.sv
// tb_si_tx_phy: self-checking bench for si_tx_phy with QUANTUM_CYCLES=4.
// A waveform-queue model is compared every cycle, plus literal spot checks.
module tb_si_tx_phy;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_reset, tx_start;
    logic [6:0]  tx_length;
    logic [31:0] tx_data;
    logic [2:0]  tx_wmask;
    logic        si_dq_i;
    logic        si_dq_oe, tx_busy, tx_error;

    int total = 0;
    int bad   = 0;

    logic tr_oe   [2048];
    logic tr_busy [2048];

    // model state
    logic        mq[$];
    logic [31:0] mbuf [3];
    logic        merr;
    int          fc;

    always #5 clk = ~clk;

    si_tx_phy #(.QUANTUM_CYCLES(Q)) dut (
        .clk       (clk),
        .reset_n   (rst_n),
        .tx_reset  (tx_reset),
        .tx_start  (tx_start),
        .tx_length (tx_length),
        .tx_data   (tx_data),
        .tx_wmask  (tx_wmask),
        .si_dq_i   (si_dq_i),
        .si_dq_oe  (si_dq_oe),
        .tx_busy   (tx_busy),
        .tx_error  (tx_error)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected oe waveform for one whole frame, one entry per clk cycle.
    task automatic model_fill(input int len);
        int l;
        logic b;
        l = (len > 12) ? 12 : len;
        mq.delete();
        for (int i = 0; i < 8 * l; i++) begin
            b = mbuf[i / 32][31 - (i % 32)];
            for (int qq = 0; qq < 4; qq++)
                for (int c = 0; c < Q; c++)
                    mq.push_back(qq < (b ? 1 : 3));
        end
        for (int qq = 0; qq < 4; qq++)
            for (int c = 0; c < Q; c++)
                mq.push_back(qq < 2);
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        logic busy0, abort;
        if (!rst_n) begin
            mq.delete();
            for (int k = 0; k < 3; k++) mbuf[k] = '0;
            merr = 1'b0;
            fc   = 0;
        end else begin
            busy0 = (mq.size() != 0);
            abort = 1'b0;
`ifdef SI_TX_LINE_CHECK_EN
            if (busy0 && mq[0] == 1'b0 && (fc % Q) == Q - 1 && !si_dq_i)
                abort = 1'b1;
`endif
            if (!busy0)
                for (int k = 0; k < 3; k++)
                    if (tx_wmask[k]) mbuf[k] = tx_data;
            if (tx_reset) begin
                mq.delete();
                merr = 1'b0;
            end else if (abort) begin
                mq.delete();
                merr = 1'b1;
            end else if (busy0) begin
                void'(mq.pop_front());
                fc++;
            end else if (tx_start) begin
                model_fill(int'(tx_length));
                merr = 1'b0;
                fc   = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (rst_n) begin
            chk("cyc_oe", si_dq_oe, (mq.size() != 0) ? mq[0] : 1'b0);
            chk("cyc_busy", tx_busy, mq.size() != 0);
            chk("cyc_err", tx_error, merr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int k, input logic [31:0] d);
        tx_wmask = 3'(1 << k);
        tx_data  = d;
        tick();
        tx_wmask = '0;
    endtask

    task automatic do_start(input logic [6:0] len);
        tx_start  = 1'b1;
        tx_length = len;
        tick();
        tx_start  = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_oe[k]   = si_dq_oe;
            tr_busy[k] = tx_busy;
        end
    endtask

    function automatic int count_ones(input int n, input bit use_oe);
        int s = 0;
        for (int k = 0; k < n; k++)
            s += use_oe ? int'(tr_oe[k]) : int'(tr_busy[k]);
        return s;
    endfunction

    initial begin
        rst_n     = 1'b0;
        tx_reset  = 1'b0;
        tx_start  = 1'b0;
        tx_length = '0;
        tx_data   = '0;
        tx_wmask  = '0;
        si_dq_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_oe", si_dq_oe, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_err", tx_error, 0);
        tick();

        // frame 05 00 02
        write_word(0, 32'h0500_0200);
        do_start(7'd3);
        capture(410);
        tick();
        chk("f1_cell0_low_start", tr_oe[0], 1);
        chk("f1_cell0_low_end", tr_oe[11], 1);
        chk("f1_cell0_high", tr_oe[12], 0);
        chk("f1_cell0_high_end", tr_oe[15], 0);
        chk("f1_bit5_low", tr_oe[80], 1);
        chk("f1_bit5_low_end", tr_oe[83], 1);
        chk("f1_bit5_high", tr_oe[84], 0);
        chk("f1_stop_low", tr_oe[384], 1);
        chk("f1_stop_low_end", tr_oe[391], 1);
        chk("f1_guard", tr_oe[392], 0);
        chk("f1_busy_last", tr_busy[399], 1);
        chk("f1_busy_after", tr_busy[400], 0);
        chk("f1_busy_cycles", count_ones(410, 0), 400);

        // stop bit only
        do_start(7'd0);
        capture(20);
        tick();
        chk("l0_oe_cycles", count_ones(20, 1), 8);
        chk("l0_oe_first8", tr_oe[7], 1);
        chk("l0_busy_cycles", count_ones(20, 0), 16);

        // clamp 15 -> 12
        write_word(1, 32'h1234_5678);
        write_word(2, 32'h0000_0001);
        do_start(7'd15);
        capture(1560);
        tick();
        chk("l15_busy_cycles", count_ones(1560, 0), 1552);
        chk("l15_bit95_low", tr_oe[1523], 1);
        chk("l15_bit95_high", tr_oe[1524], 0);
        chk("l15_stop_low", tr_oe[1536], 1);

        // start and write mid-frame are ignored
        do_start(7'd1);
        repeat (20) tick();
        tx_start  = 1'b1;
        tx_length = 7'd3;
        tx_wmask  = 3'b001;
        tx_data   = 32'hFFFF_FFFF;
        tick();
        tx_start  = 1'b0;
        tx_wmask  = '0;
        capture(130);
        tick();
        chk("mid_busy_rest", count_ones(130, 0), 123);

        // synchronous abort then resend intact buffer
        do_start(7'd3);
        repeat (49) tick();
        tx_reset = 1'b1;
        tick();
        tx_reset = 1'b0;
        @(negedge clk);
        chk("abort_oe", si_dq_oe, 0);
        chk("abort_busy", tx_busy, 0);
        tick();
        do_start(7'd1);
        capture(150);
        tick();
        chk("resend_low", tr_oe[11], 1);
        chk("resend_high", tr_oe[12], 0);
        chk("resend_busy", count_ones(150, 0), 144);

        // reset wins over start
        tx_reset  = 1'b1;
        tx_start  = 1'b1;
        tx_length = 7'd1;
        tick();
        tx_reset = 1'b0;
        tx_start = 1'b0;
        @(negedge clk);
        chk("rs_same_busy", tx_busy, 0);
        tick();

        // line pulled low during a released quantum
        do_start(7'd1);
        repeat (12) tick();
        si_dq_i = 1'b0;
        repeat (8) tick();
        si_dq_i = 1'b1;
        repeat (140) tick();
        @(negedge clk);
`ifdef SI_TX_LINE_CHECK_EN
        chk("line_err", tx_error, 1);
`else
        chk("line_err", tx_error, 0);
`endif
        tick();
        do_start(7'd0);
        repeat (20) tick();

        // async reset mid low phase
        do_start(7'd1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe", si_dq_oe, 0);
        chk("async_busy", tx_busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_oe", si_dq_oe, 0);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_err", tx_error, 0);
        tick();
        do_start(7'd1);
        repeat (150) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
